fetch_decode_ctrl: RTL and testbench

Multi-cycle fetch/decode sequencer that sits directly upstream of the ALU. It owns the program counter and fetches 9-bit instructions from the instruction ROM. It decodes each instruction into the ALU command/immediate/shift-direction controls plus register-file and data-memory strobes, and resolves BR using the ALU's `br_logic` result from the most recent CMP.

---
 rtl/fetch_decode_ctrl.sv | 140 ++++++++++++++
 tb/tb_fetch_decode_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_decode_ctrl.sv
// Multi-cycle fetch/decode sequencer: owns the PC, fetches 9-bit instructions,
// decodes ALU/register/memory controls and resolves BR against the CMP flag.
module fetch_decode_ctrl #(
    parameter int              PC_W       = 8,
    parameter logic [PC_W-1:0] START_ADDR = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [8:0]      instr,
    input  logic            br_logic,
    output logic [PC_W-1:0] imem_addr,
    output logic [2:0]      alu_cmd,
    output logic [1:0]      immed,
    output logic            direct,
    output logic [2:0]      rd_addr,
    output logic [2:0]      rs_addr,
    output logic            reg_we,
    output logic            reg_wsel,
    output logic            dmem_re,
    output logic            dmem_we,
    output logic            busy,
    output logic            done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_LDWAIT,
        S_DONE
    } state_t;

    localparam logic [2:0] OP_LDR = 3'b000;
    localparam logic [2:0] OP_STR = 3'b001;
    localparam logic [2:0] OP_CMP = 3'b110;
    localparam logic [2:0] OP_BR  = 3'b111;

    state_t          state, state_n;
    logic [PC_W-1:0] pc, pc_n;
    logic [8:0]      ir, ir_n;
    logic            f, f_n;

    logic [2:0]      op;
    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] pc_off;
    logic            is_ldr, is_str, is_cmp, is_br, is_alu;

    assign op     = ir[8:6];
    assign pc_inc = pc + PC_W'(1);
    // Offset is sign-extended so negative branches wrap modulo 2^PC_W
    assign pc_off = pc + {{(PC_W-6){ir[5]}}, ir[5:0]};

    assign is_ldr = (op == OP_LDR);
    assign is_str = (op == OP_STR);
    assign is_cmp = (op == OP_CMP);
    assign is_br  = (op == OP_BR);
    assign is_alu = !(is_ldr || is_str || is_cmp || is_br);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            pc    <= START_ADDR;
            ir    <= '0;
            f     <= 1'b0;
        end else begin
            state <= state_n;
            pc    <= pc_n;
            ir    <= ir_n;
            f     <= f_n;
        end
    end

    always_comb begin
        state_n  = state;
        pc_n     = pc;
        ir_n     = ir;
        f_n      = f;
        reg_we   = 1'b0;
        reg_wsel = 1'b0;
        dmem_re  = 1'b0;
        dmem_we  = 1'b0;
        unique case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    pc_n    = START_ADDR;
                    f_n     = 1'b0;
                    state_n = S_FETCH;
                end
            end
            S_FETCH: begin
                ir_n    = instr;
                state_n = S_EXEC;
            end
            S_EXEC: begin
                state_n = S_FETCH;
                pc_n    = pc_inc;
                unique case (1'b1)
                    is_alu: reg_we = 1'b1;
                    is_str: dmem_we = 1'b1;
                    is_ldr: begin
                        dmem_re = 1'b1;
                        pc_n    = pc;
                        state_n = S_LDWAIT;
                    end
                    is_cmp: f_n = br_logic;
                    is_br: begin
                        f_n = 1'b0;
                        if (ir[5:0] == 6'd0) begin
                            pc_n    = pc;
                            state_n = S_DONE;
                        end else if (f) begin
                            pc_n = pc_off;
                        end
                    end
                    default: ;
                endcase
            end
            S_LDWAIT: begin
                dmem_re  = 1'b1;
                reg_we   = 1'b1;
                reg_wsel = 1'b1;
                pc_n     = pc_inc;
                state_n  = S_FETCH;
            end
            default: state_n = S_IDLE;
        endcase
    end

    assign imem_addr = pc;
    assign alu_cmd   = ir[8:6];
    assign immed     = ir[1:0];
    assign direct    = ir[2];
    assign rd_addr   = ir[5:3];
    assign rs_addr   = ir[2:0];
    assign busy      = (state == S_FETCH) || (state == S_EXEC)
                    || (state == S_LDWAIT);
    assign done      = (state == S_DONE);

endmodule

// File: tb/tb_fetch_decode_ctrl.sv
// Bench for fetch_decode_ctrl: ROM-driven programs, per-cycle expected
// output records queued at stimulus time and compared as the DUT steps.
module tb_fetch_decode_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [8:0] instr;
    logic       br_logic = 1'b0;
    logic [7:0] imem_addr;
    logic [2:0] alu_cmd;
    logic [1:0] immed;
    logic       direct;
    logic [2:0] rd_addr;
    logic [2:0] rs_addr;
    logic       reg_we, reg_wsel, dmem_re, dmem_we, busy, done;

    logic [8:0] rom [256];
    assign instr = rom[imem_addr];

    fetch_decode_ctrl #(.PC_W(8), .START_ADDR(8'd0)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .instr(instr),
        .br_logic(br_logic), .imem_addr(imem_addr), .alu_cmd(alu_cmd),
        .immed(immed), .direct(direct), .rd_addr(rd_addr),
        .rs_addr(rs_addr), .reg_we(reg_we), .reg_wsel(reg_wsel),
        .dmem_re(dmem_re), .dmem_we(dmem_we), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef logic [13:0] rec_t;
    rec_t exp_q[$];
    rec_t e;
    int   checks = 0;
    int   errors = 0;

    // {addr, reg_we, reg_wsel, dmem_re, dmem_we, busy, done}
    function automatic rec_t mk(int a, bit we, bit ws, bit re, bit dw,
                                bit bz, bit dn);
        return {8'(a), we, ws, re, dw, bz, dn};
    endfunction

    function automatic rec_t obs();
        return {imem_addr, reg_we, reg_wsel, dmem_re, dmem_we, busy, done};
    endfunction

    function automatic void push_ins(int a, bit we);
        exp_q.push_back(mk(a, 0, 0, 0, 0, 1, 0));
        exp_q.push_back(mk(a, we, 0, 0, 0, 1, 0));
    endfunction

    function automatic void push_done(int a);
        exp_q.push_back(mk(a, 0, 0, 0, 0, 0, 1));
        exp_q.push_back(mk(a, 0, 0, 0, 0, 0, 1));
    endfunction

    task automatic clear_rom();
        foreach (rom[i]) rom[i] = 9'b111_000_000;
    endtask

    task automatic kick();
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++;
        if ({obs(), alu_cmd, immed, direct, rd_addr, rs_addr} !== '0) begin
            errors++;
            $display("FAIL reset_hold got %h/%h want 0", obs(),
                     {alu_cmd, immed, direct, rd_addr, rs_addr});
        end
        for (int i = 0; i < 5; i++) exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int n = 0; exp_q.size() > 0; n++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL reset_idle cyc%0d got %h want %h", n, obs(), e);
            end
        end
    endtask

    task automatic test_straight();
        clear_rom();
        rom[0] = 9'b010_001_011;
        rom[1] = 9'b101_001_010;
        rom[2] = 9'b011_001_010;
        for (int a = 0; a < 3; a++) push_ins(a, 1);
        push_ins(3, 0);
        push_done(3);
        kick();
        for (int n = 0; exp_q.size() > 0; n++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL straight cyc%0d got %h want %h", n, obs(), e);
            end
            if (n == 1) begin
                checks++;
                if ({alu_cmd, rd_addr, rs_addr, immed, direct}
                    !== {3'd2, 3'd1, 3'd3, 2'd3, 1'b0}) begin
                    errors++;
                    $display("FAIL decode_mov got %h want %h",
                             {alu_cmd, rd_addr, rs_addr, immed, direct},
                             {3'd2, 3'd1, 3'd3, 2'd3, 1'b0});
                end
            end
            if (n == 3) begin
                checks++;
                if ({alu_cmd, immed, direct} !== {3'd5, 2'd2, 1'b0}) begin
                    errors++;
                    $display("FAIL decode_shift got %h want %h",
                             {alu_cmd, immed, direct}, {3'd5, 2'd2, 1'b0});
                end
            end
        end
    endtask

    task automatic test_ldr_str();
        clear_rom();
        rom[0] = 9'b000_010_000;
        rom[1] = 9'b001_010_000;
        exp_q.push_back(mk(0, 0, 0, 0, 0, 1, 0));
        exp_q.push_back(mk(0, 0, 0, 1, 0, 1, 0));
        exp_q.push_back(mk(0, 1, 1, 1, 0, 1, 0));
        exp_q.push_back(mk(1, 0, 0, 0, 0, 1, 0));
        exp_q.push_back(mk(1, 0, 0, 0, 1, 1, 0));
        push_ins(2, 0);
        push_done(2);
        kick();
        for (int n = 0; exp_q.size() > 0; n++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL ldr_str cyc%0d got %h want %h", n, obs(), e);
            end
        end
    endtask

    task automatic test_branch(bit taken);
        clear_rom();
        for (int a = 0; a < 4; a++) rom[a] = 9'b010_001_001;
        rom[4] = 9'b110_000_001;
        rom[5] = 9'b111_000_011;
        rom[8] = 9'b111_000_010;
        br_logic = taken;
        for (int a = 0; a < 4; a++) push_ins(a, 1);
        push_ins(4, 0);
        push_ins(5, 0);
        if (taken) begin
            push_ins(8, 0);
            push_ins(9, 0);
            push_done(9);
        end else begin
            push_ins(6, 0);
            push_done(6);
        end
        kick();
        for (int n = 0; exp_q.size() > 0; n++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL branch_t%0d cyc%0d got %h want %h",
                         taken, n, obs(), e);
            end
        end
        br_logic = 1'b0;
    endtask

    task automatic test_wrap();
        clear_rom();
        rom[0]   = 9'b111_111110;
        rom[1]   = 9'b110_000_000;
        rom[2]   = 9'b111_111101;
        rom[255] = 9'b110_000_000;
        br_logic = 1'b1;
        push_ins(0, 0);
        push_ins(1, 0);
        push_ins(2, 0);
        push_ins(255, 0);
        push_ins(0, 0);
        push_ins(254, 0);
        push_done(254);
        kick();
        for (int n = 0; exp_q.size() > 0; n++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL wrap cyc%0d got %h want %h", n, obs(), e);
            end
        end
        br_logic = 1'b0;
    endtask

    task automatic test_reset_mid_ldr();
        clear_rom();
        rom[0] = 9'b000_011_000;
        exp_q.push_back(mk(0, 0, 0, 0, 0, 1, 0));
        exp_q.push_back(mk(0, 0, 0, 1, 0, 1, 0));
        exp_q.push_back(mk(0, 1, 1, 1, 0, 1, 0));
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        kick();
        for (int n = 0; exp_q.size() > 0; n++) begin
            if (n == 3) begin
                rst_n = 1'b0;
                #1;
            end else if (n == 4) begin
                @(posedge clk);
                #1 rst_n = 1'b1;
                @(negedge clk);
            end else begin
                @(negedge clk);
            end
            e = exp_q.pop_front();
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL rst_ldr step%0d got %h want %h", n, obs(), e);
            end
            if (n == 1) begin
                start = 1'b1;
                @(posedge clk);
                #1 start = 1'b0;
            end
        end
    endtask

    initial begin
        clear_rom();
        test_reset();
        test_straight();
        test_ldr_str();
        test_branch(1'b1);
        test_branch(1'b0);
        test_wrap();
        test_reset_mid_ldr();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
